// File: rtl/region_resp_mux.sv
// Collects complete responses from N_REGIONS operator regions and forwards them, one region at a
// time, as ordered meta/hdr/bdy streams. A round-robin grant is held until the response ends.
module region_resp_mux #(
    parameter int unsigned HTTP_DATA_WIDTH      = 512,
    parameter int unsigned HTTP_META_WIDTH      = 98,
    parameter int unsigned HTTP_META_META_WIDTH = 48,
    parameter int unsigned HTTP_METHOD_WIDTH    = 32,
    parameter int unsigned OPERATOR_ID_WIDTH    = 16,
    parameter int unsigned N_REGIONS            = 4
) (
    input  logic                                   aclk,
    input  logic                                   aresetn,

    input  logic [N_REGIONS-1:0]                   r_meta_tvalid,
    output logic [N_REGIONS-1:0]                   r_meta_tready,
    input  logic [N_REGIONS*HTTP_META_WIDTH-1:0]   r_meta_tdata,

    input  logic [N_REGIONS-1:0]                   r_hdr_tvalid,
    output logic [N_REGIONS-1:0]                   r_hdr_tready,
    input  logic [N_REGIONS-1:0]                   r_hdr_tlast,
    input  logic [N_REGIONS*HTTP_DATA_WIDTH-1:0]   r_hdr_tdata,

    input  logic [N_REGIONS-1:0]                   r_bdy_tvalid,
    output logic [N_REGIONS-1:0]                   r_bdy_tready,
    input  logic [N_REGIONS-1:0]                   r_bdy_tlast,
    input  logic [N_REGIONS*HTTP_DATA_WIDTH-1:0]   r_bdy_tdata,

    output logic                                   meta_src_tvalid,
    input  logic                                   meta_src_tready,
    output logic [HTTP_META_WIDTH-1:0]             meta_src_tdata,

    output logic                                   hdr_src_tvalid,
    input  logic                                   hdr_src_tready,
    output logic                                   hdr_src_tlast,
    output logic [HTTP_DATA_WIDTH-1:0]             hdr_src_tdata,

    output logic                                   bdy_src_tvalid,
    input  logic                                   bdy_src_tready,
    output logic                                   bdy_src_tlast,
    output logic [HTTP_DATA_WIDTH-1:0]             bdy_src_tdata,

    output logic [$clog2(N_REGIONS)-1:0]           grant_id,
    output logic [31:0]                            resp_cnt
);

    localparam int unsigned GW          = $clog2(N_REGIONS);
    localparam int unsigned HAS_HDR_BIT = HTTP_META_META_WIDTH + HTTP_METHOD_WIDTH;
    localparam int unsigned HAS_BDY_BIT = HTTP_META_WIDTH - OPERATOR_ID_WIDTH - 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        META = 2'd1,
        HDR  = 2'd2,
        BDY  = 2'd3
    } state_t;

    state_t          state;
    logic [GW-1:0]   last_grant;
    logic            has_hdr;
    logic            has_bdy;

    logic            arb_found;
    logic [GW-1:0]   arb_idx;

    logic            meta_hs;
    logic            hdr_done;
    logic            bdy_done;

    // Round-robin pick: first meta requester strictly after last_grant.
    always_comb begin
        int unsigned cand;
        arb_found = 1'b0;
        arb_idx   = '0;
        cand      = 0;
        for (int unsigned k = 1; k <= N_REGIONS; k++) begin
            cand = (32'(last_grant) + k) % N_REGIONS;
            if (!arb_found && r_meta_tvalid[cand]) begin
                arb_found = 1'b1;
                arb_idx   = GW'(cand);
            end
        end
    end

    // Zero-latency output mux; only the stream of the current state is live.
    always_comb begin
        int unsigned g;
        g               = 32'(grant_id);
        meta_src_tvalid = 1'b0;
        hdr_src_tvalid  = 1'b0;
        hdr_src_tlast   = 1'b0;
        bdy_src_tvalid  = 1'b0;
        bdy_src_tlast   = 1'b0;
        r_meta_tready   = '0;
        r_hdr_tready    = '0;
        r_bdy_tready    = '0;
        meta_src_tdata  = r_meta_tdata[g*HTTP_META_WIDTH +: HTTP_META_WIDTH];
        hdr_src_tdata   = r_hdr_tdata[g*HTTP_DATA_WIDTH +: HTTP_DATA_WIDTH];
        bdy_src_tdata   = r_bdy_tdata[g*HTTP_DATA_WIDTH +: HTTP_DATA_WIDTH];
        case (state)
            META: begin
                meta_src_tvalid  = r_meta_tvalid[g];
                r_meta_tready[g] = meta_src_tready;
            end
            HDR: begin
                hdr_src_tvalid  = r_hdr_tvalid[g];
                hdr_src_tlast   = r_hdr_tlast[g];
                r_hdr_tready[g] = hdr_src_tready;
            end
            BDY: begin
                bdy_src_tvalid  = r_bdy_tvalid[g];
                bdy_src_tlast   = r_bdy_tlast[g];
                r_bdy_tready[g] = bdy_src_tready;
            end
            default: ;
        endcase
    end

    assign meta_hs  = meta_src_tvalid && meta_src_tready;
    assign hdr_done = hdr_src_tvalid && hdr_src_tready && hdr_src_tlast;
    assign bdy_done = bdy_src_tvalid && bdy_src_tready && bdy_src_tlast;

    // Response sequencing, grant ownership and completion counting.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state      <= IDLE;
            last_grant <= GW'(N_REGIONS - 1);
            grant_id   <= '0;
            resp_cnt   <= '0;
            has_hdr    <= 1'b0;
            has_bdy    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (arb_found) begin
                        grant_id   <= arb_idx;
                        last_grant <= arb_idx;
                        state      <= META;
                    end
                end
                META: begin
                    if (meta_hs) begin
                        has_hdr <= meta_src_tdata[HAS_HDR_BIT];
                        has_bdy <= meta_src_tdata[HAS_BDY_BIT];
                        if (meta_src_tdata[HAS_HDR_BIT]) begin
                            state <= HDR;
                        end else if (meta_src_tdata[HAS_BDY_BIT]) begin
                            state <= BDY;
                        end else begin
                            state    <= IDLE;
                            resp_cnt <= resp_cnt + 32'd1;
                        end
                    end
                end
                HDR: begin
                    if (hdr_done) begin
                        if (has_bdy) begin
                            state <= BDY;
                        end else begin
                            state    <= IDLE;
                            resp_cnt <= resp_cnt + 32'd1;
                        end
                    end
                end
                BDY: begin
                    if (bdy_done) begin
                        state    <= IDLE;
                        resp_cnt <= resp_cnt + 32'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_region_resp_mux.sv
// Directed per-cycle vectors for region_resp_mux: each record gives the region inputs for one
// cycle and the outputs expected while that cycle is in progress.
module tb_region_resp_mux;

    localparam int unsigned DW = 512;
    localparam int unsigned MW = 98;
    localparam int unsigned NR = 4;

    logic              aclk;
    logic              aresetn;
    logic [NR-1:0]     r_meta_tvalid, r_meta_tready;
    logic [NR*MW-1:0]  r_meta_tdata;
    logic [NR-1:0]     r_hdr_tvalid, r_hdr_tready, r_hdr_tlast;
    logic [NR*DW-1:0]  r_hdr_tdata;
    logic [NR-1:0]     r_bdy_tvalid, r_bdy_tready, r_bdy_tlast;
    logic [NR*DW-1:0]  r_bdy_tdata;
    logic              meta_src_tvalid, meta_src_tready;
    logic [MW-1:0]     meta_src_tdata;
    logic              hdr_src_tvalid, hdr_src_tready, hdr_src_tlast;
    logic [DW-1:0]     hdr_src_tdata;
    logic              bdy_src_tvalid, bdy_src_tready, bdy_src_tlast;
    logic [DW-1:0]     bdy_src_tdata;
    logic [1:0]        grant_id;
    logic [31:0]       resp_cnt;

    region_resp_mux dut (
        .aclk            (aclk),
        .aresetn         (aresetn),
        .r_meta_tvalid   (r_meta_tvalid),
        .r_meta_tready   (r_meta_tready),
        .r_meta_tdata    (r_meta_tdata),
        .r_hdr_tvalid    (r_hdr_tvalid),
        .r_hdr_tready    (r_hdr_tready),
        .r_hdr_tlast     (r_hdr_tlast),
        .r_hdr_tdata     (r_hdr_tdata),
        .r_bdy_tvalid    (r_bdy_tvalid),
        .r_bdy_tready    (r_bdy_tready),
        .r_bdy_tlast     (r_bdy_tlast),
        .r_bdy_tdata     (r_bdy_tdata),
        .meta_src_tvalid (meta_src_tvalid),
        .meta_src_tready (meta_src_tready),
        .meta_src_tdata  (meta_src_tdata),
        .hdr_src_tvalid  (hdr_src_tvalid),
        .hdr_src_tready  (hdr_src_tready),
        .hdr_src_tlast   (hdr_src_tlast),
        .hdr_src_tdata   (hdr_src_tdata),
        .bdy_src_tvalid  (bdy_src_tvalid),
        .bdy_src_tready  (bdy_src_tready),
        .bdy_src_tlast   (bdy_src_tlast),
        .bdy_src_tdata   (bdy_src_tdata),
        .grant_id        (grant_id),
        .resp_cnt        (resp_cnt)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    typedef struct {
        logic        rstn;
        logic [3:0]  mv, hv, hl, bv, bl;
        logic [2:0]  rdy;      // {meta, hdr, bdy} src tready
        logic [1:0]  hb;       // {has_body, has_headers} for every region's meta word
        logic [7:0]  beat;
        logic [4:0]  ev;       // {meta_v, hdr_v, hdr_l, bdy_v, bdy_l}
        logic [3:0]  emt, eht, ebt;
        logic [1:0]  eg;
        logic [31:0] ecnt;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    task automatic add(input logic rstn, input logic [3:0] mv, hv, hl, bv, bl,
                       input logic [2:0] rdy, input logic [1:0] hb, input logic [7:0] beat,
                       input logic [4:0] ev, input logic [3:0] emt, eht, ebt,
                       input logic [1:0] eg, input logic [31:0] ecnt);
        vec_t v;
        v.rstn = rstn; v.mv = mv; v.hv = hv; v.hl = hl; v.bv = bv; v.bl = bl;
        v.rdy = rdy; v.hb = hb; v.beat = beat; v.ev = ev;
        v.emt = emt; v.eht = eht; v.ebt = ebt; v.eg = eg; v.ecnt = ecnt;
        vecs.push_back(v);
    endtask

    function automatic logic [MW-1:0] meta_word(input int i, input logic [1:0] hb);
        return {16'(i), hb, 32'h5000_0000 | 32'(i), 48'h1234_0000_0000 | 48'(i)};
    endfunction

    function automatic logic [DW-1:0] beat_word(input int i, input logic [7:0] beat, input bit is_bdy);
        logic [DW-1:0] w;
        w        = '0;
        w[15:0]  = 16'(beat);
        w[31:16] = 16'(i);
        w[63:32] = is_bdy ? 32'hB0D7_0000 : 32'h0EAD_0000;
        return w;
    endfunction

    task automatic drive(input vec_t v);
        aresetn         = v.rstn;
        r_meta_tvalid   = v.mv;
        r_hdr_tvalid    = v.hv;
        r_hdr_tlast     = v.hl;
        r_bdy_tvalid    = v.bv;
        r_bdy_tlast     = v.bl;
        meta_src_tready = v.rdy[2];
        hdr_src_tready  = v.rdy[1];
        bdy_src_tready  = v.rdy[0];
        for (int i = 0; i < int'(NR); i++) begin
            r_meta_tdata[i*MW +: MW] = meta_word(i, v.hb);
            r_hdr_tdata[i*DW +: DW]  = beat_word(i, v.beat, 1'b0);
            r_bdy_tdata[i*DW +: DW]  = beat_word(i, v.beat, 1'b1);
        end
    endtask

    task automatic check_vec(input int idx, input vec_t v);
        logic [16:0] act_ctl, exp_ctl;
        act_ctl = {meta_src_tvalid, hdr_src_tvalid, hdr_src_tlast, bdy_src_tvalid, bdy_src_tlast,
                   r_meta_tready, r_hdr_tready, r_bdy_tready};
        exp_ctl = {v.ev, v.emt, v.eht, v.ebt};
        checks++;
        if (act_ctl !== exp_ctl) begin
            errors++;
            $display("FAIL vec%0d ctl: got %05h expected %05h", idx, act_ctl, exp_ctl);
        end
        checks++;
        if (grant_id !== v.eg) begin
            errors++;
            $display("FAIL vec%0d grant_id: got %0d expected %0d", idx, grant_id, v.eg);
        end
        checks++;
        if (resp_cnt !== v.ecnt) begin
            errors++;
            $display("FAIL vec%0d resp_cnt: got %0d expected %0d", idx, resp_cnt, v.ecnt);
        end
        if (v.ev[4]) begin
            checks++;
            if (meta_src_tdata !== meta_word(int'(v.eg), v.hb)) begin
                errors++;
                $display("FAIL vec%0d meta_data: got %h expected %h", idx, meta_src_tdata,
                         meta_word(int'(v.eg), v.hb));
            end
        end
        if (v.ev[3]) begin
            checks++;
            if (hdr_src_tdata[63:0] !== beat_word(int'(v.eg), v.beat, 1'b0) >> 0 ||
                hdr_src_tdata[DW-1:64] !== '0) begin
                errors++;
                $display("FAIL vec%0d hdr_data: got %h expected region %0d beat %0d", idx,
                         hdr_src_tdata[63:0], v.eg, v.beat);
            end
        end
        if (v.ev[1]) begin
            checks++;
            if (bdy_src_tdata !== beat_word(int'(v.eg), v.beat, 1'b1)) begin
                errors++;
                $display("FAIL vec%0d bdy_data: got %h expected region %0d beat %0d", idx,
                         bdy_src_tdata[63:0], v.eg, v.beat);
            end
        end
    endtask

    initial begin
        vec_t rv;
        // Region 1 alone: meta, 2 header beats, 3 body beats.
        add(1, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 3'b111, 2'b11, 8'd0, 5'b00000, 4'b0000, 4'b0000, 4'b0000, 2'd0, 32'd0);
        add(1, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 3'b111, 2'b11, 8'd0, 5'b10000, 4'b0010, 4'b0000, 4'b0000, 2'd1, 32'd0);
        add(1, 4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 3'b111, 2'b11, 8'd0, 5'b01000, 4'b0000, 4'b0010, 4'b0000, 2'd1, 32'd0);
        add(1, 4'b0000, 4'b0010, 4'b0010, 4'b0000, 4'b0000, 3'b111, 2'b11, 8'd1, 5'b01100, 4'b0000, 4'b0010, 4'b0000, 2'd1, 32'd0);
        add(1, 4'b0000, 4'b0000, 4'b0000, 4'b0010, 4'b0000, 3'b111, 2'b11, 8'd0, 5'b00010, 4'b0000, 4'b0000, 4'b0010, 2'd1, 32'd0);
        add(1, 4'b0000, 4'b0000, 4'b0000, 4'b0010, 4'b0000, 3'b111, 2'b11, 8'd1, 5'b00010, 4'b0000, 4'b0000, 4'b0010, 2'd1, 32'd0);
        add(1, 4'b0000, 4'b0000, 4'b0000, 4'b0010, 4'b0010, 3'b111, 2'b11, 8'd2, 5'b00011, 4'b0000, 4'b0000, 4'b0010, 2'd1, 32'd0);
        add(1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 3'b111, 2'b11, 8'd0, 5'b00000, 4'b0000, 4'b0000, 4'b0000, 2'd1, 32'd1);
        // Reset, then all four regions request meta-only responses.
        add(0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 3'b111, 2'b00, 8'd0, 5'b00000, 4'b0000, 4'b0000, 4'b0000, 2'd1, 32'd1);
        add(1, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 3'b111, 2'b00, 8'd0, 5'b00000, 4'b0000, 4'b0000, 4'b0000, 2'd0, 32'd0);
        add(1, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 3'b111, 2'b00, 8'd0, 5'b10000, 4'b0001, 4'b0000, 4'b0000, 2'd0, 32'd0);
        add(1, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 3'b111, 2'b00, 8'd0, 5'b00000, 4'b0000, 4'b0000, 4'b0000, 2'd0, 32'd1);
        add(1, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 3'b111, 2'b00, 8'd0, 5'b10000, 4'b0010, 4'b0000, 4'b0000, 2'd1, 32'd1);
        add(1, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 3'b111, 2'b00, 8'd0, 5'b00000, 4'b0000, 4'b0000, 4'b0000, 2'd1, 32'd2);
        add(1, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 3'b111, 2'b00, 8'd0, 5'b10000, 4'b0100, 4'b0000, 4'b0000, 2'd2, 32'd2);
        add(1, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 3'b111, 2'b00, 8'd0, 5'b00000, 4'b0000, 4'b0000, 4'b0000, 2'd2, 32'd3);
        add(1, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 3'b111, 2'b00, 8'd0, 5'b10000, 4'b1000, 4'b0000, 4'b0000, 2'd3, 32'd3);
        add(1, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 3'b111, 2'b00, 8'd0, 5'b00000, 4'b0000, 4'b0000, 4'b0000, 2'd3, 32'd4);
        add(1, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 3'b111, 2'b00, 8'd0, 5'b10000, 4'b0001, 4'b0000, 4'b0000, 2'd0, 32'd4);
        add(1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 3'b111, 2'b00, 8'd0, 5'b00000, 4'b0000, 4'b0000, 4'b0000, 2'd0, 32'd5);
        // Region 2 body-only; region 0 requests and offers stray body beats mid-body.
        add(1, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 3'b111, 2'b10, 8'd0, 5'b00000, 4'b0000, 4'b0000, 4'b0000, 2'd0, 32'd5);
        add(1, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 3'b111, 2'b10, 8'd0, 5'b10000, 4'b0100, 4'b0000, 4'b0000, 2'd2, 32'd5);
        add(1, 4'b0001, 4'b0000, 4'b0000, 4'b0101, 4'b0000, 3'b111, 2'b10, 8'd0, 5'b00010, 4'b0000, 4'b0000, 4'b0100, 2'd2, 32'd5);
        add(1, 4'b0001, 4'b0000, 4'b0000, 4'b0101, 4'b0100, 3'b111, 2'b10, 8'd1, 5'b00011, 4'b0000, 4'b0000, 4'b0100, 2'd2, 32'd5);
        add(1, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 3'b111, 2'b00, 8'd0, 5'b00000, 4'b0000, 4'b0000, 4'b0000, 2'd2, 32'd6);
        add(1, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 3'b111, 2'b00, 8'd0, 5'b10000, 4'b0001, 4'b0000, 4'b0000, 2'd0, 32'd6);
        add(1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 3'b111, 2'b00, 8'd0, 5'b00000, 4'b0000, 4'b0000, 4'b0000, 2'd0, 32'd7);
        // Region 3 body with toggling bdy_src_tready and a dropped valid.
        add(1, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 3'b111, 2'b10, 8'd0, 5'b00000, 4'b0000, 4'b0000, 4'b0000, 2'd0, 32'd7);
        add(1, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 3'b111, 2'b10, 8'd0, 5'b10000, 4'b1000, 4'b0000, 4'b0000, 2'd3, 32'd7);
        add(1, 4'b0000, 4'b0000, 4'b0000, 4'b1000, 4'b0000, 3'b111, 2'b10, 8'd0, 5'b00010, 4'b0000, 4'b0000, 4'b1000, 2'd3, 32'd7);
        add(1, 4'b0000, 4'b0000, 4'b0000, 4'b1000, 4'b0000, 3'b110, 2'b10, 8'd1, 5'b00010, 4'b0000, 4'b0000, 4'b0000, 2'd3, 32'd7);
        add(1, 4'b0000, 4'b0000, 4'b0000, 4'b1000, 4'b0000, 3'b111, 2'b10, 8'd1, 5'b00010, 4'b0000, 4'b0000, 4'b1000, 2'd3, 32'd7);
        add(1, 4'b0000, 4'b0000, 4'b0000, 4'b1000, 4'b0000, 3'b110, 2'b10, 8'd2, 5'b00010, 4'b0000, 4'b0000, 4'b0000, 2'd3, 32'd7);
        add(1, 4'b0000, 4'b0000, 4'b0000, 4'b1000, 4'b0000, 3'b111, 2'b10, 8'd2, 5'b00010, 4'b0000, 4'b0000, 4'b1000, 2'd3, 32'd7);
        add(1, 4'b0000, 4'b0000, 4'b0000, 4'b1000, 4'b1000, 3'b110, 2'b10, 8'd3, 5'b00011, 4'b0000, 4'b0000, 4'b0000, 2'd3, 32'd7);
        add(1, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 3'b111, 2'b10, 8'd3, 5'b00000, 4'b0000, 4'b0000, 4'b1000, 2'd3, 32'd7);
        add(1, 4'b0001, 4'b0000, 4'b0000, 4'b1000, 4'b1000, 3'b111, 2'b10, 8'd3, 5'b00011, 4'b0000, 4'b0000, 4'b1000, 2'd3, 32'd7);
        add(1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 3'b111, 2'b10, 8'd0, 5'b00000, 4'b0000, 4'b0000, 4'b0000, 2'd3, 32'd8);
        // Region 1 meta-only while it also offers hdr/bdy beats.
        add(1, 4'b0010, 4'b0010, 4'b0000, 4'b0010, 4'b0000, 3'b111, 2'b00, 8'd0, 5'b00000, 4'b0000, 4'b0000, 4'b0000, 2'd3, 32'd8);
        add(1, 4'b0010, 4'b0010, 4'b0000, 4'b0010, 4'b0000, 3'b111, 2'b00, 8'd0, 5'b10000, 4'b0010, 4'b0000, 4'b0000, 2'd1, 32'd8);
        add(1, 4'b0000, 4'b0010, 4'b0000, 4'b0010, 4'b0000, 3'b111, 2'b00, 8'd0, 5'b00000, 4'b0000, 4'b0000, 4'b0000, 2'd1, 32'd9);
        // Reset sampled during region 2 header beat 2.
        add(1, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 3'b111, 2'b11, 8'd0, 5'b00000, 4'b0000, 4'b0000, 4'b0000, 2'd1, 32'd9);
        add(1, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 3'b111, 2'b11, 8'd0, 5'b10000, 4'b0100, 4'b0000, 4'b0000, 2'd2, 32'd9);
        add(1, 4'b0000, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 3'b111, 2'b11, 8'd0, 5'b01000, 4'b0000, 4'b0100, 4'b0000, 2'd2, 32'd9);
        add(0, 4'b1111, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 3'b111, 2'b11, 8'd1, 5'b01000, 4'b0000, 4'b0100, 4'b0000, 2'd2, 32'd9);
        add(1, 4'b1111, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 3'b111, 2'b00, 8'd1, 5'b00000, 4'b0000, 4'b0000, 4'b0000, 2'd0, 32'd0);
        add(1, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 3'b111, 2'b00, 8'd0, 5'b10000, 4'b0001, 4'b0000, 4'b0000, 2'd0, 32'd0);
        add(1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 3'b111, 2'b00, 8'd0, 5'b00000, 4'b0000, 4'b0000, 4'b0000, 2'd0, 32'd1);

        // Initial reset with every input asserted: outputs must stay quiet.
        rv = '{rstn: 1'b0, mv: 4'b1111, hv: 4'b1111, hl: 4'b1111, bv: 4'b1111, bl: 4'b1111,
               rdy: 3'b111, hb: 2'b11, beat: 8'd0, ev: 5'b00000, emt: 4'b0000, eht: 4'b0000,
               ebt: 4'b0000, eg: 2'd0, ecnt: 32'd0};
        drive(rv);
        @(negedge aclk);
        @(negedge aclk);
        #1;
        check_vec(-1, rv);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge aclk);
            drive(vecs[i]);
            #1;
            check_vec(i, vecs[i]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
